// File: rtl/data_mem.sv
// Byte-addressable data memory with a valid/ready request channel and a
// registered valid/ready response channel. One request may be outstanding;
// with the consumer always ready it sustains one request per cycle.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no response held, rsp_valid low
// S_RESP | response registered and presented, waiting for rsp_ready
module data_mem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_fault;

  // Contents are deliberately left out of reset so data survives it.
  logic [31:0] r_mem [DEPTH];

  logic             w_accept;
  logic [1:0]       w_off;
  logic [IDX_W-1:0] w_idx;
  logic             w_oob;
  logic             w_fault;
  logic [3:0]       w_be;
  logic [31:0]      w_wlanes;
  logic [31:0]      w_word;
  logic [31:0]      w_shifted;
  logic [31:0]      w_load_data;
  logic [31:0]      w_rsp_next;

  assign req_ready = !reset && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_fault = r_rsp_fault;

  assign w_off = req_addr[1:0];
  assign w_idx = req_addr[IDX_W+1:2];

  // Any set address bit above the in-range word index means out of range.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_oob
      assign w_oob = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_oob
      assign w_oob = 1'b0;
    end
  endgenerate

  // Fault on illegal size, misaligned half/word, or out-of-range index.
  always_comb begin
    w_fault = w_oob;
    case (req_size)
      SZ_BYTE: ;
      SZ_HALF: if (w_off[0]) w_fault = 1'b1;
      SZ_WORD: if (w_off != 2'b00) w_fault = 1'b1;
      default: w_fault = 1'b1;
    endcase
  end

  // Replicate store data onto every lane and pick lanes by byte enable.
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        w_be     = 4'b0001 << w_off;
        w_wlanes = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be     = w_off[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_be     = 4'b1111;
        w_wlanes = req_wdata;
      end
      default: w_be = 4'b0000;
    endcase
  end

  assign w_word    = r_mem[w_idx];
  assign w_shifted = w_word >> {w_off, 3'b000};

  // Right-align the selected byte/half and extend it.
  always_comb begin
    w_load_data = w_word;
    case (req_size)
      SZ_BYTE: w_load_data = {{24{req_signed & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_load_data = {{16{req_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = w_word;
    endcase
  end

  assign w_rsp_next = (w_fault || req_we) ? 32'h0 : w_load_data;

  // Lane-masked store at the acceptance edge; faulting stores write nothing.
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  // Response FSM; registered outputs hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_next;
            r_rsp_fault <= w_fault;
          end
        end
        S_RESP: begin
          if (w_accept) begin
            r_rsp_rdata <= w_rsp_next;
            r_rsp_fault <= w_fault;
          end else if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_fault <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: scoreboard of expected responses pushed
// when a request is driven and popped when the response is sampled.
module tb_data_mem;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb [$];

  typedef struct packed {
    logic [95:0] nm;
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic        ef;
    logic [31:0] ed;
  } op_t;

  data_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault)
  );

  always #5 clk = ~clk;

  function automatic op_t mk(input logic [95:0] nm, input logic we, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a, input logic [31:0] wd,
                             input logic ef, input logic [31:0] ed);
    op_t o;
    o.nm = nm; o.we = we; o.sz = sz; o.sg = sg; o.a = a; o.wd = wd; o.ef = ef; o.ed = ed;
    return o;
  endfunction

  task automatic present(input op_t o);
    req_valid  = 1'b1;
    req_we     = o.we;
    req_size   = o.sz;
    req_signed = o.sg;
    req_addr   = o.a;
    req_wdata  = o.wd;
    sb.push_back({o.ef, o.ed});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_fault, rsp_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b f=%0b d=%08h, want v=0 f=0 d=00000000",
               rsp_valid, rsp_fault, rsp_rdata);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %0b, want 0", req_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b, want 1", req_ready);
    end
    tick();
  endtask

  task automatic test_sign_ext();
    op_t ops [$];
    logic [32:0] e;
    ops.push_back(mk("st_w_10",  1, 2'b10, 0, 32'h10, 32'h80FF7F01, 0, 32'h0));
    ops.push_back(mk("ldsb_11",  0, 2'b00, 1, 32'h11, 32'h0,        0, 32'h0000007F));
    ops.push_back(mk("ldsb_13",  0, 2'b00, 1, 32'h13, 32'h0,        0, 32'hFFFFFF80));
    ops.push_back(mk("ldub_13",  0, 2'b00, 0, 32'h13, 32'h0,        0, 32'h00000080));
    ops.push_back(mk("ldsh_12",  0, 2'b01, 1, 32'h12, 32'h0,        0, 32'hFFFF80FF));
    ops.push_back(mk("lduh_10",  0, 2'b01, 0, 32'h10, 32'h0,        0, 32'h00007F01));
    foreach (ops[i]) begin
      present(ops[i]);
      tick();
      req_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, e}) begin
        errors++;
        $display("FAIL %s: got v=%0b f=%0b d=%08h, want v=1 f=%0b d=%08h",
                 ops[i].nm, rsp_valid, rsp_fault, rsp_rdata, e[32], e[31:0]);
      end
    end
    tick();
  endtask

  task automatic test_byte_store();
    op_t ops [$];
    logic [32:0] e;
    ops.push_back(mk("stb_12",   1, 2'b00, 0, 32'h12, 32'h123456AB, 0, 32'h0));
    ops.push_back(mk("ldw_10",   0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h80AB7F01));
    foreach (ops[i]) begin
      present(ops[i]);
      tick();
      req_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, e}) begin
        errors++;
        $display("FAIL %s: got v=%0b f=%0b d=%08h, want v=1 f=%0b d=%08h",
                 ops[i].nm, rsp_valid, rsp_fault, rsp_rdata, e[32], e[31:0]);
      end
    end
    tick();
  endtask

  task automatic test_half_and_misalign();
    op_t ops [$];
    logic [32:0] e;
    ops.push_back(mk("sth_16",   1, 2'b01, 0, 32'h16, 32'hFFFF8001, 0, 32'h0));
    ops.push_back(mk("ldsh_16",  0, 2'b01, 1, 32'h16, 32'h0,        0, 32'hFFFF8001));
    ops.push_back(mk("ldub_17",  0, 2'b00, 0, 32'h17, 32'h0,        0, 32'h00000080));
    ops.push_back(mk("stw_20",   1, 2'b10, 0, 32'h20, 32'h11223344, 0, 32'h0));
    ops.push_back(mk("stw_22",   1, 2'b10, 0, 32'h22, 32'hDEADBEEF, 1, 32'h0));
    ops.push_back(mk("sth_21",   1, 2'b01, 0, 32'h21, 32'h0000BEEF, 1, 32'h0));
    ops.push_back(mk("ldh_15",   0, 2'b01, 1, 32'h15, 32'h0,        1, 32'h0));
    ops.push_back(mk("ldw_20",   0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h11223344));
    foreach (ops[i]) begin
      present(ops[i]);
      tick();
      req_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, e}) begin
        errors++;
        $display("FAIL %s: got v=%0b f=%0b d=%08h, want v=1 f=%0b d=%08h",
                 ops[i].nm, rsp_valid, rsp_fault, rsp_rdata, e[32], e[31:0]);
      end
    end
    tick();
  endtask

  task automatic test_range_fault();
    op_t ops [$];
    logic [32:0] e;
    logic [31:0] top;
    top = DEPTH * 4;
    ops.push_back(mk("stw_last", 1, 2'b10, 0, top - 4,      32'hA5C3E1F0, 0, 32'h0));
    ops.push_back(mk("ldw_last", 0, 2'b10, 0, top - 4,      32'h0,        0, 32'hA5C3E1F0));
    ops.push_back(mk("ldub_top", 0, 2'b00, 0, top - 1,      32'h0,        0, 32'h000000A5));
    ops.push_back(mk("ldw_oob",  0, 2'b10, 0, top,          32'h0,        1, 32'h0));
    ops.push_back(mk("stw_oob",  1, 2'b10, 0, top,          32'h55555555, 1, 32'h0));
    ops.push_back(mk("ldw_hi",   0, 2'b10, 0, 32'h80000010, 32'h0,        1, 32'h0));
    ops.push_back(mk("sz11_ld",  0, 2'b11, 0, 32'h10,       32'h0,        1, 32'h0));
    ops.push_back(mk("sz11_st",  1, 2'b11, 0, 32'h10,       32'hFFFFFFFF, 1, 32'h0));
    ops.push_back(mk("ldw_10b",  0, 2'b10, 1, 32'h10,       32'h0,        0, 32'h80AB7F01));
    foreach (ops[i]) begin
      present(ops[i]);
      tick();
      req_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, e}) begin
        errors++;
        $display("FAIL %s: got v=%0b f=%0b d=%08h, want v=1 f=%0b d=%08h",
                 ops[i].nm, rsp_valid, rsp_fault, rsp_rdata, e[32], e[31:0]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    op_t ops [$];
    logic [32:0] e;
    ops.push_back(mk("b2b_stw",  1, 2'b10, 0, 32'h30, 32'hCAFEF00D, 0, 32'h0));
    ops.push_back(mk("b2b_ldw",  0, 2'b10, 0, 32'h30, 32'h0,        0, 32'hCAFEF00D));
    ops.push_back(mk("b2b_sth",  1, 2'b01, 0, 32'h32, 32'h00001234, 0, 32'h0));
    ops.push_back(mk("b2b_ldw2", 0, 2'b10, 1, 32'h30, 32'h0,        0, 32'h1234F00D));
    ops.push_back(mk("b2b_ldub", 0, 2'b00, 0, 32'h31, 32'h0,        0, 32'h000000F0));
    ops.push_back(mk("b2b_ldsh", 0, 2'b01, 1, 32'h30, 32'h0,        0, 32'hFFFFF00D));
    ops.push_back(mk("b2b_ldsb", 0, 2'b00, 1, 32'h33, 32'h0,        0, 32'h00000012));
    foreach (ops[i]) begin
      present(ops[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, e}) begin
        errors++;
        $display("FAIL %s: got v=%0b f=%0b d=%08h, want v=1 f=%0b d=%08h",
                 ops[i].nm, rsp_valid, rsp_fault, rsp_rdata, e[32], e[31:0]);
      end
    end
    req_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got rsp_valid=%0b, want 0", rsp_valid);
    end
  endtask

  task automatic test_stall();
    logic [32:0] e;
    present(mk("stall_ld1", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h80AB7F01));
    tick();
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, e}) begin
      errors++;
      $display("FAIL stall_ld1: got v=%0b f=%0b d=%08h, want v=1 f=%0b d=%08h",
               rsp_valid, rsp_fault, rsp_rdata, e[32], e[31:0]);
    end
    rsp_ready = 1'b0;
    present(mk("stall_ld2", 0, 2'b00, 0, 32'h10, 32'h0, 0, 32'h00000001));
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready cyc%0d: got %0b, want 0", k, req_ready);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_fault, rsp_rdata} !== {2'b10, 32'h80AB7F01}) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: got v=%0b f=%0b d=%08h, want v=1 f=0 d=80ab7f01",
                 k, rsp_valid, rsp_fault, rsp_rdata);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %0b, want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, e}) begin
      errors++;
      $display("FAIL stall_ld2: got v=%0b f=%0b d=%08h, want v=1 f=%0b d=%08h",
               rsp_valid, rsp_fault, rsp_rdata, e[32], e[31:0]);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    logic [32:0] e;
    rsp_ready = 1'b0;
    present(mk("rst_ld1", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h80AB7F01));
    tick();
    req_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, e}) begin
      errors++;
      $display("FAIL rst_pending: got v=%0b f=%0b d=%08h, want v=1 f=%0b d=%08h",
               rsp_valid, rsp_fault, rsp_rdata, e[32], e[31:0]);
    end
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_wdata  = 32'hDEADBEEF;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: got %0b, want 0", req_ready);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_fault, rsp_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL rst_drop: got v=%0b f=%0b d=%08h, want v=0 f=0 d=00000000",
               rsp_valid, rsp_fault, rsp_rdata);
    end
    tick();
    reset     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_accept: got rsp_valid=%0b, want 0", rsp_valid);
    end
    present(mk("rst_ld2", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h80AB7F01));
    tick();
    req_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, e}) begin
      errors++;
      $display("FAIL rst_retained: got v=%0b f=%0b d=%08h, want v=1 f=%0b d=%08h",
               rsp_valid, rsp_fault, rsp_rdata, e[32], e[31:0]);
    end
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;
    test_reset();
    test_sign_ext();
    test_byte_store();
    test_half_and_misalign();
    test_range_fault();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words stored (power of two, 4..4096).
REQ-002 The module SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-003 The module SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-004 The module SHALL have port clk, input, 1 bit: clock.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 The module SHALL have port req_valid, input, 1 bit: request present.
REQ-007 The module SHALL have port req_ready, output, 1 bit: request can be accepted this cycle.
REQ-008 The module SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 The module SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 The module SHALL have port req_signed, input, 1 bit: sign-extend load data (LDRSB/LDRSH); ignored for word accesses and stores.
REQ-011 The module SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-012 The module SHALL have port req_wdata, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 The module SHALL have port rsp_valid, output, 1 bit: response present.
REQ-014 The module SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-015 The module SHALL have port rsp_rdata, output, 32 bits: load result, right-aligned and extended.
REQ-016 The module SHALL have port rsp_fault, output, 1 bit: the request was rejected.

Function
REQ-017 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-018 req_ready SHALL equal !rsp_valid || rsp_ready, giving one outstanding request and 1 request/cycle throughput when rsp_ready is held high.
REQ-019 Control SHALL be a two-state FSM: IDLE (rsp_valid=0) and RESP (rsp_valid=1).
REQ-020 IDLE SHALL go to RESP on acceptance.
REQ-021 RESP SHALL stay in RESP on response handshake plus new acceptance, go to IDLE on handshake without acceptance, and hold on no handshake.
REQ-022 The response SHALL appear exactly 1 cycle after acceptance and be registered.
REQ-023 rsp_rdata and rsp_fault SHALL remain stable while rsp_valid && !rsp_ready.
REQ-024 The word index SHALL be req_addr[ADDR_W-1:2]; the lane offset SHALL be req_addr[1:0].
REQ-025 A request SHALL fault when req_size == 11; when a half access has addr[0] == 1; when a word access has addr[1:0] != 0; or when the word index is >= DEPTH.
REQ-026 A faulting request SHALL still be accepted and SHALL return rsp_fault=1 with rsp_rdata=0; a faulting store SHALL modify no memory.
REQ-027 A non-faulting store SHALL write only the addressed lanes at the acceptance edge: byte writes lane addr[1:0] with wdata[7:0]; half writes lanes {addr[1],0}..+1 with wdata[15:0]; word writes all lanes. Other lanes SHALL be preserved.
REQ-028 A store response SHALL have rsp_fault=0 and rsp_rdata=0.
REQ-029 A load SHALL read the addressed word at the acceptance edge.
REQ-030 A load SHALL select the addressed byte or half, then zero-extend it, or sign-extend it when req_signed=1 and the access is byte or half.
REQ-031 A load accepted the cycle after a store to the same word SHALL return the post-store data.
REQ-032 Memory contents SHALL NOT be initialised by reset; contents are undefined until written.

Reset
REQ-033 While reset is high, rsp_valid, rsp_fault and rsp_rdata SHALL become 0 and the FSM SHALL enter IDLE at the next edge.
REQ-034 While reset is high, req_ready SHALL be 0 and no request SHALL be accepted, so a store presented during reset does not write.
REQ-035 A response pending when reset asserts SHALL be dropped.
REQ-036 Memory contents SHALL be retained across reset.

Verification
REQ-037 The bench SHALL cover: word store 0x80FF7F01 @0x10, then byte load @0x11 signed -> rsp_rdata 0x0000007F; byte load @0x13 signed -> 0xFFFFFF80; byte load @0x13 unsigned -> 0x00000080.
REQ-038 The bench SHALL cover: byte store 0xAB @0x12 over 0x80FF7F01, then word load @0x10 -> 0x80AB7F01 (neighbouring lanes preserved).
REQ-039 The bench SHALL cover: half store 0x8001 @0x16, then half load @0x16 signed -> 0xFFFF8001; word store @0x22 -> rsp_fault=1, and a word load @0x20 afterwards shows unchanged contents.
REQ-040 The bench SHALL cover: word load @ (DEPTH*4) -> rsp_fault=1 and rsp_rdata=0; req_size=11 -> rsp_fault=1.
REQ-041 The bench SHALL cover: rsp_ready held 0 for 3 cycles -> req_ready=0 and rsp_rdata stable; rsp_ready held 1 with back-to-back requests -> one response per cycle.
REQ-042 The bench SHALL cover: reset asserted with rsp_valid=1 -> rsp_valid=0 next cycle; a store presented during reset is not written, and earlier data is still readable after reset.
